// File: rtl/fpga_common_pkg.sv
// Definitions shared by the UART receive and transmit paths in fpga_common.
package fpga_common_pkg;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;
endpackage

// File: rtl/debug_trace_receive_uart_receive.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, one-cycle byte strobe.
module uart_receive
  import fpga_common_pkg::*;
#(
  parameter int BAUD_DIVIDE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uart_rx,
  output logic [UART_DATA_BITS-1:0] rx_char,
  output logic                      rx_char_valid,
  output logic                      frame_err,
  output logic                      rx_idle
);
  localparam int CW = $clog2(BAUD_DIVIDE) + 1;
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_BAUD = CW'(BAUD_DIVIDE / 2);
  localparam logic [CW-1:0] FULL_BAUD = CW'(BAUD_DIVIDE);
  localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

  logic rx_meta_p0, rx_sync_p1;
  uart_rx_state_t state, state_nx;
  logic [CW-1:0] bit_cnt, bit_cnt_nx;
  logic [BW-1:0] bit_idx, bit_idx_nx;
  logic [UART_DATA_BITS-1:0] shift, shift_nx;
  logic brk_wait, brk_wait_nx;
  logic char_valid_nx, frame_err_nx;
  logic expire;

  // Synchroniser boundary: everything below sees only rx_sync_p1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_meta_p0 <= uart_rx;
      rx_sync_p1 <= rx_meta_p0;
    end
  end

  assign expire = (bit_cnt <= CW'(1));

  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    bit_idx_nx    = bit_idx;
    shift_nx      = shift;
    brk_wait_nx   = brk_wait;
    char_valid_nx = 1'b0;
    frame_err_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync_p1) begin
          state_nx   = START;
          bit_cnt_nx = HALF_BAUD;
        end
      end
      START: begin
        if (!expire) begin
          bit_cnt_nx = bit_cnt - CW'(1);
        end else if (rx_sync_p1) begin
          state_nx = IDLE;
        end else begin
          state_nx   = DATA;
          bit_cnt_nx = FULL_BAUD;
          bit_idx_nx = '0;
        end
      end
      DATA: begin
        if (!expire) begin
          bit_cnt_nx = bit_cnt - CW'(1);
        end else begin
          shift_nx   = {rx_sync_p1, shift[UART_DATA_BITS-1:1]};
          bit_cnt_nx = FULL_BAUD;
          bit_idx_nx = bit_idx + BW'(1);
          if (bit_idx == LAST_BIT) state_nx = STOP;
        end
      end
      STOP: begin
        // After a bad stop bit, hold here until the line returns high
        if (brk_wait) begin
          if (rx_sync_p1) begin
            brk_wait_nx = 1'b0;
            state_nx    = IDLE;
          end
        end else if (!expire) begin
          bit_cnt_nx = bit_cnt - CW'(1);
        end else if (rx_sync_p1) begin
          char_valid_nx = 1'b1;
          state_nx      = IDLE;
        end else begin
          frame_err_nx = 1'b1;
          brk_wait_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      brk_wait      <= 1'b0;
      rx_char_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_nx;
      bit_cnt       <= bit_cnt_nx;
      bit_idx       <= bit_idx_nx;
      brk_wait      <= brk_wait_nx;
      rx_char_valid <= char_valid_nx;
      frame_err     <= frame_err_nx;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nx;
  end

  assign rx_char = shift;
  assign rx_idle = (state == IDLE);
endmodule

// File: rtl/sram_1r1w.sv
// Simple dual-port storage: one synchronous write port, one combinational read port.
module sram_1r1w #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/debug_trace_receive.sv
// Host-to-FPGA debug channel: UART bytes are packed LSB-first into words and queued in a FIFO.
module debug_trace_receive
  import fpga_common_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_SIZE     = 8,
  parameter int BAUD_DIVIDE   = 1,
  parameter int TIMEOUT_BAUDS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  frame_err,
  output logic                  overflow
);
  localparam int NB  = (DATA_WIDTH + 7) / 8;
  localparam int AW8 = NB * 8;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
  localparam int TO_LIMIT = TIMEOUT_BAUDS * BAUD_DIVIDE;
  localparam int TW  = $clog2(TO_LIMIT + 1);
  localparam int FAW = $clog2(FIFO_SIZE);

  logic [UART_DATA_BITS-1:0] rx_char;
  logic rx_char_valid, rx_idle;

  uart_receive #(.BAUD_DIVIDE(BAUD_DIVIDE)) u_uart_receive (
    .clk          (clk),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .rx_char      (rx_char),
    .rx_char_valid(rx_char_valid),
    .frame_err    (frame_err),
    .rx_idle      (rx_idle)
  );

  logic [IW-1:0]  byte_idx;
  logic [AW8-1:0] asm_word, byte_ext, asm_merged;
  logic [TW-1:0]  idle_cnt;
  logic           push, push_ok, pop, full;
  logic [DATA_WIDTH-1:0] push_word, mem_rd_data;

  assign byte_ext   = AW8'(rx_char) << {byte_idx, 3'b000};
  assign asm_merged = asm_word | byte_ext;
  assign push       = rx_char_valid && (byte_idx == LAST_IDX);
  assign push_word  = asm_merged[DATA_WIDTH-1:0];

  // Assembly stage: byte index, partial word, inter-byte idle timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      asm_word <= '0;
      idle_cnt <= '0;
    end else if (frame_err) begin
      byte_idx <= '0;
      asm_word <= '0;
      idle_cnt <= '0;
    end else if (rx_char_valid) begin
      idle_cnt <= '0;
      if (push) begin
        byte_idx <= '0;
        asm_word <= '0;
      end else begin
        byte_idx <= byte_idx + IW'(1);
        asm_word <= asm_merged;
      end
    end else if ((byte_idx != '0) && rx_idle) begin
      if (idle_cnt == TW'(TO_LIMIT - 1)) begin
        byte_idx <= '0;
        asm_word <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end else begin
      idle_cnt <= '0;
    end
  end

  logic [FAW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [FAW:0]   count, count_nx;

  assign pop       = out_valid && out_ready;
  assign full      = (count == (FAW+1)'(FIFO_SIZE));
  assign push_ok   = push && (!full || pop);
  assign rd_ptr_nx = rd_ptr + FAW'(pop);
  assign count_nx  = count + (FAW+1)'(push_ok) - (FAW+1)'(pop);
  assign out_valid = (count != '0);

  sram_1r1w #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_SIZE)) u_sram_1r1w (
    .clk    (clk),
    .wr_en  (push_ok),
    .wr_addr(wr_ptr),
    .wr_data(push_word),
    .rd_addr(rd_ptr_nx),
    .rd_data(mem_rd_data)
  );

  // FIFO stage: out_data mirrors the next head; a word written into an otherwise empty queue bypasses the RAM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      out_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + FAW'(push_ok);
      rd_ptr <= rd_ptr_nx;
      count  <= count_nx;
      if (push && !push_ok) overflow <= 1'b1;
      if (count_nx != '0) begin
        out_data <= (push_ok && (count_nx == (FAW+1)'(1))) ? push_word : mem_rd_data;
      end
    end
  end
endmodule

// File: tb/tb_debug_trace_receive.sv
// Randomized self-checking bench: a 32-bit and a 20-bit receiver against a queue-based model.
module tb_debug_trace_receive;
  localparam int BAUD     = 8;
  localparam int FIFO     = 4;
  localparam int TO_BAUDS = 16;

  logic clk = 1'b0;
  logic reset;
  logic rx32, rx20;
  logic out_valid32, out_ready32, frame_err32, overflow32;
  logic [31:0] out_data32;
  logic out_valid20, out_ready20, frame_err20, overflow20;
  logic [19:0] out_data20;

  always #5 clk = ~clk;

  debug_trace_receive #(.DATA_WIDTH(32), .FIFO_SIZE(FIFO), .BAUD_DIVIDE(BAUD),
                        .TIMEOUT_BAUDS(TO_BAUDS)) dut32 (
    .clk(clk), .reset(reset), .uart_rx(rx32), .out_valid(out_valid32),
    .out_data(out_data32), .out_ready(out_ready32), .frame_err(frame_err32),
    .overflow(overflow32)
  );

  debug_trace_receive #(.DATA_WIDTH(20), .FIFO_SIZE(FIFO), .BAUD_DIVIDE(BAUD),
                        .TIMEOUT_BAUDS(TO_BAUDS)) dut20 (
    .clk(clk), .reset(reset), .uart_rx(rx20), .out_valid(out_valid20),
    .out_data(out_data20), .out_ready(out_ready20), .frame_err(frame_err20),
    .overflow(overflow20)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: partial byte lists, expected word queues, expected flags
  logic [7:0]  part32[$];
  logic [7:0]  part20[$];
  logic [31:0] exp32[$];
  logic [19:0] exp20[$];
  logic ovf32_exp = 1'b0;
  int ferr32_exp = 0;

  task automatic model_good(input int sel, input logic [7:0] b);
    logic [63:0] w;
    w = '0;
    if (sel == 0) begin
      part32.push_back(b);
      if (part32.size() == 4) begin
        foreach (part32[k]) w = w | (64'(part32[k]) << (8 * k));
        part32.delete();
        if (exp32.size() >= FIFO) ovf32_exp = 1'b1;
        else exp32.push_back(w[31:0]);
      end
    end else begin
      part20.push_back(b);
      if (part20.size() == 3) begin
        foreach (part20[k]) w = w | (64'(part20[k]) << (8 * k));
        part20.delete();
        exp20.push_back(w[19:0]);
      end
    end
  endtask

  task automatic model_bad(input int sel);
    if (sel == 0) begin
      part32.delete();
      ferr32_exp++;
    end else begin
      part20.delete();
    end
  endtask

  task automatic model_timeout(input int sel);
    if (sel == 0) part32.delete();
    else part20.delete();
  endtask

  task automatic model_reset();
    part32.delete();
    part20.delete();
    exp32.delete();
    exp20.delete();
    ovf32_exp = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx32 = v;
    else rx20 = v;
  endtask

  task automatic drive_byte(input int sel, input logic [7:0] b, input bit stop_ok);
    set_line(sel, 1'b0);
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, b[i]);
      tick(BAUD);
    end
    set_line(sel, stop_ok);
    tick(BAUD);
    if (!stop_ok) begin
      set_line(sel, 1'b1);
      tick(BAUD);
    end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input bit stop_ok);
    if (stop_ok) model_good(sel, b);
    else model_bad(sel);
    drive_byte(sel, b, stop_ok);
  endtask

  task automatic send_word32(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(0, w[8*k +: 8], 1'b1);
  endtask

  // Output monitor: every pop is compared against the head of the expected queue
  int pops32 = 0, pops20 = 0, ferr32 = 0, ferr20 = 0;
  logic [31:0] last32 = '0;
  logic [19:0] last20 = '0;
  logic [31:0] exp_head;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid32 && out_ready32) begin
        pops32++;
        last32 = out_data32;
        if (exp32.size() == 0) check("pop32_unexpected", 32'(exp32.size()), 32'd1);
        else begin
          exp_head = exp32.pop_front();
          check("pop32_data", out_data32, exp_head);
        end
      end
      if (out_valid20 && out_ready20) begin
        pops20++;
        last20 = out_data20;
        if (exp20.size() == 0) check("pop20_unexpected", 32'(exp20.size()), 32'd1);
        else begin
          exp_head = 32'(exp20.pop_front());
          check("pop20_data", 32'(out_data20), exp_head);
        end
      end
      if (frame_err32) ferr32++;
      if (frame_err20) ferr20++;
    end
  end

  logic rand_ready = 1'b0;
  logic ready_cmd  = 1'b1;

  initial begin
    out_ready32 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready32 = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete within the time budget");
    $fatal(1);
  end

  int p0, f0;
  logic [7:0] rb;
  bit ok;

  initial begin
    reset = 1'b1;
    rx32 = 1'b1;
    rx20 = 1'b1;
    out_ready20 = 1'b1;
    tick(4);
    @(negedge clk);
    check("rst_valid32", 32'(out_valid32), 32'd0);
    check("rst_data32", out_data32, 32'd0);
    check("rst_ferr32", 32'(frame_err32), 32'd0);
    check("rst_ovf32", 32'(overflow32), 32'd0);
    check("rst_valid20", 32'(out_valid20), 32'd0);
    check("rst_data20", 32'(out_data20), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick(4);

    // Basic word, LSB first
    send_byte(0, 8'h78, 1'b1);
    send_byte(0, 8'h56, 1'b1);
    send_byte(0, 8'h34, 1'b1);
    send_byte(0, 8'h12, 1'b1);
    tick(20);
    check("t1_pops", 32'(pops32), 32'd1);
    check("t1_word", last32, 32'h12345678);
    check("t1_ferr", 32'(ferr32), 32'd0);
    check("t1_ovf", 32'(overflow32), 32'd0);

    // 20-bit word: padding bits above DATA_WIDTH are discarded
    send_byte(1, 8'hAB, 1'b1);
    send_byte(1, 8'hCD, 1'b1);
    send_byte(1, 8'hEF, 1'b1);
    tick(20);
    check("t2_word_a", 32'(last20), 32'h000FCDAB);
    send_byte(1, 8'h01, 1'b1);
    send_byte(1, 8'h02, 1'b1);
    send_byte(1, 8'h03, 1'b1);
    tick(20);
    check("t2_word_b", 32'(last20), 32'h00030201);
    check("t2_pops", 32'(pops20), 32'd2);

    // Idle timeout discards a partial word
    p0 = pops32;
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    tick(20 * BAUD);
    model_timeout(0);
    send_word32(32'h11223344);
    tick(20);
    check("t3_pops", 32'(pops32 - p0), 32'd1);
    check("t3_word", last32, 32'h11223344);

    // Framing error resets the byte index
    p0 = pops32;
    send_byte(0, 8'hA1, 1'b1);
    send_byte(0, 8'hA2, 1'b1);
    send_byte(0, 8'hA3, 1'b0);
    send_word32(32'hDEADBEEF);
    tick(20);
    check("t4_ferr", 32'(ferr32), 32'(ferr32_exp));
    check("t4_pops", 32'(pops32 - p0), 32'd1);
    check("t4_word", last32, 32'hDEADBEEF);

    // Overflow with a stalled consumer
    ready_cmd = 1'b0;
    tick(3);
    for (int n = 0; n < 5; n++) send_word32($urandom);
    tick(20);
    check("t5_valid", 32'(out_valid32), 32'd1);
    check("t5_ovf", 32'(overflow32), 32'(ovf32_exp));
    check("t5_held", 32'(exp32.size()), 32'd4);
    check("t5_head", out_data32, exp32[0]);
    ready_cmd = 1'b1;
    tick(20);
    check("t5_drained", 32'(exp32.size()), 32'd0);
    check("t5_ovf_sticky", 32'(overflow32), 32'd1);

    // Short low glitch must not start a byte
    p0 = pops32;
    f0 = ferr32;
    rx32 = 1'b0;
    tick(2);
    rx32 = 1'b1;
    tick(20 * BAUD);
    check("t6_glitch_pops", 32'(pops32 - p0), 32'd0);
    check("t6_glitch_ferr", 32'(ferr32 - f0), 32'd0);

    // Reset in the middle of a byte
    fork
      drive_byte(0, 8'h5A, 1'b1);
      begin
        tick(BAUD * 4 + 3);
        reset = 1'b1;
      end
    join
    tick(1);
    model_reset();
    reset = 1'b0;
    tick(2);
    check("t6_rst_ovf", 32'(overflow32), 32'd0);
    check("t6_rst_valid", 32'(out_valid32), 32'd0);
    p0 = pops32;
    send_word32(32'hCAFEF00D);
    tick(20);
    check("t6_pops", 32'(pops32 - p0), 32'd1);
    check("t6_word", last32, 32'hCAFEF00D);

    // Random byte stream with occasional framing errors, timeouts and back-pressure
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_byte(0, rb, ok);
      if ($urandom_range(0, 9) == 0) begin
        tick(20 * BAUD);
        model_timeout(0);
      end else begin
        tick($urandom_range(0, 4) * BAUD);
      end
    end
    rand_ready = 1'b0;
    ready_cmd = 1'b1;
    tick(30);
    check("rand_drained", 32'(exp32.size()), 32'd0);
    check("rand_ferr", 32'(ferr32), 32'(ferr32_exp));
    check("rand_ovf", 32'(overflow32), 32'(ovf32_exp));
    check("rand_no_ferr20", 32'(ferr20), 32'd0);
    check("rand_no_ovf20", 32'(overflow20), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
